// File: rtl/ddr_cmd_pkg.sv
// Shared definitions for the DDR command scheduler.
// Holds the FSM state encoding, the default beat and chunk sizes, and the
// descriptor record layout that is used at the default widths
// (64-bit address, 32-bit byte count).
package ddr_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT
  } state_t;

  localparam int DEF_BEAT_BYTES  = 32;
  localparam int DEF_CHUNK_BYTES = 4096;

  localparam int DESC_ADDR_W  = 64;
  localparam int DESC_BYTES_W = 32;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0]  addr;
    logic [DESC_BYTES_W-1:0] bytes;
    logic                    write;
  } desc_t;

endpackage

// File: rtl/ddr_desc_fifo.sv
// Synchronous register FIFO for transfer descriptors.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset (flushes the FIFO)
//   push, wdata  - write request and data (ignored when full)
//   pop          - read request (ignored when empty)
//   rdata        - head entry, valid whenever empty is low (show-ahead)
//   full, empty  - occupancy flags
// DEPTH must be a power of two and at least 2.
module ddr_desc_fifo #(
  parameter int DW    = 97,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ddr_cmd_sched.sv
// Upstream command scheduler for the AXI DDR data mover.
// Queues transfer descriptors, splits each into chunks of at most CHUNK_BYTES
// and strobes them one at a time to the mover, waiting for the mover's idle
// between chunks. Pulses desc_done once per descriptor.
// Ports:
//   clk, rst_n                          - clock, synchronous active-low reset
//   init_cmptd                          - DDR calibration done; gates new pops
//   desc_valid/desc_ready               - descriptor handshake (ready = !full)
//   desc_addr, desc_bytes, desc_write   - descriptor fields
//   ddr_st_addr_out, ddr_len, cmd_type  - chunk fields, held until next issue
//   ddr_conf                            - one-cycle chunk start strobe
//   idle                                - mover fully idle
//   desc_done                           - one-cycle descriptor completion pulse
//   busy                                - queue non-empty or FSM active
// Optional: define DDR_CMD_SCHED_PERF_EN to add perf_busy_cycles (saturating
// count of active FSM cycles) and perf_desc_count (wrapping done count).
module ddr_cmd_sched
  import ddr_cmd_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 64,
  parameter int SINGLE_LEN       = 24,
  parameter int TOTAL_LEN        = 32,
  parameter int CHUNK_BYTES      = DEF_CHUNK_BYTES,
  parameter int BEAT_BYTES       = DEF_BEAT_BYTES,
  parameter int QDEPTH           = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init_cmptd,
  input  logic                        desc_valid,
  output logic                        desc_ready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] desc_addr,
  input  logic [TOTAL_LEN-1:0]        desc_bytes,
  input  logic                        desc_write,
  output logic [C_AXI_ADDR_WIDTH-1:0] ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]       ddr_len,
  output logic                        ddr_conf,
  output logic                        cmd_type,
  input  logic                        idle,
  output logic                        desc_done,
  output logic                        busy
`ifdef DDR_CMD_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_busy_cycles,
  output logic [15:0]                 perf_desc_count
`endif
);

  localparam int DW = C_AXI_ADDR_WIDTH + TOTAL_LEN + 1;
  localparam logic [TOTAL_LEN-1:0] BEAT_MASK  = ~TOTAL_LEN'(BEAT_BYTES - 1);
  localparam logic [TOTAL_LEN-1:0] CHUNK_MAX  = TOTAL_LEN'(CHUNK_BYTES);

  state_t                      state;
  logic [C_AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [TOTAL_LEN-1:0]        rem_bytes;
  logic                        cur_write;
  logic [TOTAL_LEN-1:0]        chunk_len;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic [DW-1:0]               fifo_wdata;
  logic [DW-1:0]               fifo_rdata;
  logic [C_AXI_ADDR_WIDTH-1:0] head_addr;
  logic [TOTAL_LEN-1:0]        head_bytes;
  logic                        head_write;

  assign desc_ready = !fifo_full;
  assign fifo_push  = desc_valid && !fifo_full;
  // Byte counts are rounded down to whole beats on entry to the queue.
  assign fifo_wdata = {desc_addr, desc_bytes & BEAT_MASK, desc_write};
  assign {head_addr, head_bytes, head_write} = fifo_rdata;
  assign fifo_pop   = (state == S_IDLE) && !fifo_empty && init_cmptd && idle;
  assign busy       = !fifo_empty || (state != S_IDLE);

  ddr_desc_fifo #(
    .DW    (DW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    chunk_len = rem_bytes;
    if (rem_bytes > CHUNK_MAX) begin
      chunk_len = CHUNK_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cur_addr        <= '0;
      rem_bytes       <= '0;
      cur_write       <= 1'b0;
      ddr_conf        <= 1'b0;
      desc_done       <= 1'b0;
      ddr_st_addr_out <= '0;
      ddr_len         <= '0;
      cmd_type        <= 1'b0;
    end else begin
      ddr_conf  <= 1'b0;
      desc_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            cur_addr  <= head_addr;
            rem_bytes <= head_bytes;
            cur_write <= head_write;
            // Empty descriptors complete immediately without touching the mover.
            if (head_bytes == '0) begin
              desc_done <= 1'b1;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          ddr_conf        <= 1'b1;
          ddr_st_addr_out <= cur_addr;
          ddr_len         <= SINGLE_LEN'(chunk_len);
          cmd_type        <= cur_write;
          cur_addr        <= cur_addr + C_AXI_ADDR_WIDTH'(chunk_len);
          rem_bytes       <= rem_bytes - chunk_len;
          state           <= S_ARM;
        end
        // The mover only drops idle after seeing the strobe, so idle is
        // not trusted for one cycle here.
        S_ARM: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (idle) begin
            if (rem_bytes != '0) begin
              state <= S_ISSUE;
            end else begin
              desc_done <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DDR_CMD_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_busy_cycles <= '0;
      perf_desc_count  <= '0;
    end else begin
      if ((state != S_IDLE) && (perf_busy_cycles != '1)) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if (desc_done) begin
        perf_desc_count <= perf_desc_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Self-checking bench for ddr_cmd_sched with a scoreboard of expected
// chunk/done events and a simple behavioural mover.
module tb_ddr_cmd_sched;
  import ddr_cmd_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        init_cmptd;
  logic        desc_valid;
  logic        desc_ready;
  logic [63:0] desc_addr;
  logic [31:0] desc_bytes;
  logic        desc_write;
  logic [63:0] ddr_st_addr_out;
  logic [23:0] ddr_len;
  logic        ddr_conf;
  logic        cmd_type;
  logic        idle;
  logic        desc_done;
  logic        busy;
`ifdef DDR_CMD_SCHED_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_desc_count;
`endif

  ddr_cmd_sched #(
    .C_AXI_ADDR_WIDTH (64),
    .SINGLE_LEN       (24),
    .TOTAL_LEN        (32),
    .CHUNK_BYTES      (4096),
    .BEAT_BYTES       (32),
    .QDEPTH           (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .init_cmptd      (init_cmptd),
    .desc_valid      (desc_valid),
    .desc_ready      (desc_ready),
    .desc_addr       (desc_addr),
    .desc_bytes      (desc_bytes),
    .desc_write      (desc_write),
    .ddr_st_addr_out (ddr_st_addr_out),
    .ddr_len         (ddr_len),
    .ddr_conf        (ddr_conf),
    .cmd_type        (cmd_type),
    .idle            (idle),
    .desc_done       (desc_done),
    .busy            (busy)
`ifdef DDR_CMD_SCHED_PERF_EN
    ,
    .perf_busy_cycles(perf_busy_cycles),
    .perf_desc_count (perf_desc_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [63:0] addr;
    logic [31:0] len;
    logic        wr;
  } ev_t;

  ev_t exp_q[$];
  int  checks    = 0;
  int  failures  = 0;
  int  conf_cnt  = 0;
  int  done_cnt  = 0;
  bit  hold_busy = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expand one descriptor into its expected event sequence.
  task automatic model_desc(input desc_t d);
    logic [63:0] a;
    longint unsigned left;
    longint unsigned n;
    ev_t e;
    a    = d.addr;
    left = longint'(d.bytes) / 32 * 32;
    while (left > 0) begin
      n = (left > 4096) ? 4096 : left;
      e.is_done = 0; e.addr = a; e.len = 32'(n); e.wr = d.write;
      exp_q.push_back(e);
      a    = a + 64'(n);
      left = left - n;
    end
    e.is_done = 1; e.addr = '0; e.len = '0; e.wr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [63:0] a, input logic [31:0] b, input logic w);
    int unsigned n;
    desc_t d;
    n = 0;
    desc_valid = 1'b1; desc_addr = a; desc_bytes = b; desc_write = w;
    while (!desc_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!desc_ready) begin
      check("push_ready_timeout", 64'(desc_ready), 64'd1);
      desc_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      desc_valid = 1'b0;
      d.addr = a; d.bytes = b; d.write = w;
      model_desc(d);
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_conf"},  64'(ddr_conf), 64'd0);
    check({tag, "_done"},  64'(desc_done), 64'd0);
    check({tag, "_addr"},  ddr_st_addr_out, 64'd0);
    check({tag, "_len"},   64'(ddr_len), 64'd0);
    check({tag, "_type"},  64'(cmd_type), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(desc_ready), 64'd1);
  endtask

  // Mover: drops idle the cycle after it sees ddr_conf, stays busy for a
  // random run length; hold_busy forces it busy.
  initial begin
    int run_left;
    bit saw_conf;
    run_left = 0;
    saw_conf = 0;
    idle = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (saw_conf) begin
        run_left = $urandom_range(1, 6);
        saw_conf = 0;
      end
      if (ddr_conf) saw_conf = 1;
      idle = !(hold_busy || run_left > 0);
      if (run_left > 0) run_left--;
    end
  end

  // Monitor: pops and compares on every strobe or completion pulse.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk); #1;
      if (ddr_conf || desc_done) begin
        check("conf_done_exclusive", 64'(ddr_conf && desc_done), 64'd0);
      end
      if (ddr_conf) begin
        conf_cnt++;
        check("conf_mover_idle", 64'(idle), 64'd1);
        check("conf_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("chunk_kind", 64'(e.is_done), 64'd0);
          check("chunk_addr", ddr_st_addr_out, e.addr);
          check("chunk_len", 64'(ddr_len), 64'(e.len));
          check("chunk_type", 64'(cmd_type), 64'(e.wr));
        end
      end else if (desc_done) begin
        done_cnt++;
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_kind", 64'(e.is_done), 64'd1);
        end
      end
    end
  end

  initial begin
    int first;
    int cc;
    int dc;
    int unsigned n;
    rst_n = 1'b0; init_cmptd = 1'b1; desc_valid = 1'b0;
    desc_addr = '0; desc_bytes = '0; desc_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single short write.
    push(64'h1000, 32'h100, 1'b1);
    drain();

    // Multi-chunk read (count rounded down to whole beats).
    push(64'h0, 32'd10000, 1'b0);
    drain();

    // Zero-length descriptor.
    push(64'h2000, 32'd0, 1'b1);
    push(64'h3000, 32'd31, 1'b0);
    drain();

    // Queue fill with mover held busy.
    hold_busy = 1;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(64'h10000 * (i + 1), 32'd5000 + 32'(i) * 32, i[0]);
    check("ready_when_full", 64'(desc_ready), 64'd0);
    fork
      push(64'h50000, 32'd64, 1'b1);
      begin repeat (10) @(posedge clk); #1; hold_busy = 0; end
    join
    drain();

    // Calibration gating and release latency.
    init_cmptd = 1'b0;
    push(64'h7000, 32'd4096, 1'b1);
    push(64'h9000, 32'd96, 1'b0);
    cc = conf_cnt;
    repeat (20) @(posedge clk); #1;
    check("no_conf_while_uncalibrated", 64'(conf_cnt), 64'(cc));
    init_cmptd = 1'b1;
    first = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #2;
      if (ddr_conf && first == 0) first = k;
    end
    check("init_latency_le2", 64'(first >= 1 && first <= 2), 64'd1);
    drain();

    // Address wrap and random traffic.
    push(64'hFFFF_FFFF_FFFF_F800, 32'd8192, 1'b1);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 31)) : 32'($urandom_range(0, 14000));
      push({32'($urandom), 32'($urandom)}, b, 1'($urandom));
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
    drain();

    // Reset while waiting on the mover mid-descriptor.
    push(64'h40000, 32'd9000, 1'b0);
    n = 0;
    while (!ddr_conf && n < 200) begin @(posedge clk); #1; n++; end
    check("midreset_first_conf", 64'(ddr_conf), 64'd1);
    hold_busy = 1;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    exp_q.delete();
    rst_n = 1'b1;
    check_reset_outputs("midreset");
    cc = conf_cnt; dc = done_cnt;
    hold_busy = 0;
    repeat (60) @(posedge clk); #1;
    check("midreset_no_conf", 64'(conf_cnt), 64'(cc));
    check("midreset_no_done", 64'(done_cnt), 64'(dc));
    check("midreset_busy", 64'(busy), 64'd0);

    // Post-reset traffic still works.
    push(64'h1234_5600, 32'd4128, 1'b1);
    drain();
`ifdef DDR_CMD_SCHED_PERF_EN
    check("perf_desc_count", 64'(perf_desc_count), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
